// File: rtl/pwm_pkg.sv
// Shared defaults and decode types for the multi-channel PWM block.
package pwm_pkg;
  localparam int DEF_NUM_CH = 16;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PSC_W  = 8;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;
endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center counter and period-boundary detect.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PSC_W = DEF_PSC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PSC_W-1:0] prescale,
  input  logic [CNT_W-1:0] period_top,
  input  logic             center_mode,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             boundary
);
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  dir_e             dir, dir_nxt;
  mode_e            mode;

  assign mode = mode_e'(center_mode);
  // >= so that lowering prescale below the running count ticks right away
  assign tick = (psc_cnt >= prescale);

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (mode == MODE_EDGE) begin
      dir_nxt = DIR_UP;
      if (tick) cnt_nxt = (cnt >= period_top) ? '0 : cnt + CNT_W'(1);
    end else if (tick) begin
      if (period_top == '0) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
      end else if (dir == DIR_UP && cnt >= period_top) begin
        cnt_nxt = cnt - CNT_W'(1);
        dir_nxt = DIR_DOWN;
      end else if (dir == DIR_DOWN && cnt == '0) begin
        cnt_nxt = cnt + CNT_W'(1);
        dir_nxt = DIR_UP;
      end else begin
        cnt_nxt = (dir == DIR_UP) ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
      end
    end
  end

  assign boundary = tick && (cnt_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
      cnt     <= '0;
      dir     <= DIR_UP;
    end else begin
      psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
      cnt     <= cnt_nxt;
      dir     <= dir_nxt;
    end
  end
endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH PWM channels with double-buffered duty, sharing one timebase.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PSC_W  = DEF_PSC_W,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic              duty_wr,
  input  logic [SEL_W-1:0]  duty_sel,
  input  logic [CNT_W-1:0]  duty_wdata,
  input  logic [PSC_W-1:0]  prescale,
  input  logic [CNT_W-1:0]  period_top,
  input  logic              center_mode,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              boundary;
  logic [NUM_CH-1:0] pwm;

  pwm_timebase #(.CNT_W(CNT_W), .PSC_W(PSC_W)) u_tb (
    .clk        (clk),
    .rst_n      (rst_n),
    .prescale   (prescale),
    .period_top (period_top),
    .center_mode(center_mode),
    .cnt        (cnt),
    .tick       (tick),
    .boundary   (boundary)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shadow, active;
    logic             wr_hit;

    // Out-of-range selects never match any channel index, so they drop silently
    assign wr_hit = duty_wr && (duty_sel == SEL_W'(i));
    assign pwm[i] = (cnt < active);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (boundary) active <= shadow;
        if (wr_hit)   shadow <= duty_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= en_out & ((en_pwm & pwm) | ~en_pwm);
      period_start <= boundary;
    end
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: vector table, hand sequences and random run vs a phase-based model.
module tb_pwm_multi_channel;
  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int SW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en_out = '1, en_pwm = '1;
  logic           duty_wr = 1'b0;
  logic [SW-1:0]  duty_sel = '0;
  logic [CW-1:0]  duty_wdata = '0;
  logic [PW-1:0]  prescale = '0;
  logic [CW-1:0]  period_top = '0;
  logic           center_mode = 1'b0;
  logic [NCH-1:0] out;
  logic           period_start;

  pwm_multi_channel #(.NUM_CH(NCH), .CNT_W(CW), .PSC_W(PW), .SEL_W(SW)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_out(en_out), .en_pwm(en_pwm),
    .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_wdata(duty_wdata),
    .prescale(prescale), .period_top(period_top), .center_mode(center_mode),
    .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Model: the timebase is a pure function of the number of clocks since reset
  int             cfg_psc, cfg_top;
  bit             cfg_ctr;
  int             m_n;
  logic [CW-1:0]  m_sh [NCH];
  logic [CW-1:0]  m_act[NCH];
  logic [NCH-1:0] m_out;
  logic           m_ps;

  function automatic int cnt_of(int n);
    int k, p;
    k = n / (cfg_psc + 1);
    if (!cfg_ctr) return k % (cfg_top + 1);
    if (cfg_top == 0) return 0;
    p = k % (2 * cfg_top);
    return (p <= cfg_top) ? p : 2 * cfg_top - p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int  old_cnt;
    bit  bnd;
    @(posedge clk);
    old_cnt = cnt_of(m_n);
    m_n++;
    bnd = (m_n % (cfg_psc + 1) == 0) && (cnt_of(m_n) == 0);
    for (int i = 0; i < NCH; i++)
      m_out[i] = en_out[i] & (en_pwm[i] ? (old_cnt < int'(m_act[i])) : 1'b1);
    if (bnd) for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
    if (duty_wr && int'(duty_sel) < NCH) m_sh[duty_sel] = duty_wdata;
    m_ps = bnd;
    #1;
    check("out", 64'(out), 64'(m_out));
    check("period_start", 64'(period_start), 64'(m_ps));
    check("cnt", 64'(u_dut.cnt), 64'(cnt_of(m_n)));
  endtask

  task automatic wr(input int sel, input int data);
    duty_wr = 1'b1; duty_sel = SW'(sel); duty_wdata = CW'(data);
    step();
    duty_wr = 1'b0;
  endtask

  task automatic do_reset(input int psc, input int top, input bit ctr);
    rst_n = 1'b0; duty_wr = 1'b0;
    prescale = PW'(psc); period_top = CW'(top); center_mode = ctr;
    cfg_psc = psc; cfg_top = top; cfg_ctr = ctr;
    m_n = 0; m_out = '0; m_ps = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    #3;
    check("rst_out", 64'(out), 64'(0));
    check("rst_ps", 64'(period_start), 64'(0));
    check("rst_cnt", 64'(u_dut.cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int psc; int top; bit ctr; int duty; bit eo; bit ep;
    int exp_high; int len;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int hi, ps, first;
    bit found;

    // Per-period high count of out[0]; center mode counts cnt<duty over the triangle
    vecs.push_back('{0, 9, 0,   3, 1, 1,  3, 10});
    vecs.push_back('{0, 9, 0,   0, 1, 1,  0, 10});
    vecs.push_back('{0, 9, 0, 255, 1, 1, 10, 10});
    vecs.push_back('{0, 9, 0,   9, 1, 1,  9, 10});
    vecs.push_back('{0, 9, 0,   3, 1, 0, 10, 10});
    vecs.push_back('{0, 9, 0,   3, 0, 1,  0, 10});
    vecs.push_back('{3, 4, 1,   2, 1, 1, 12, 32});
    vecs.push_back('{3, 4, 1,   5, 1, 1, 32, 32});
    vecs.push_back('{0, 3, 1,   1, 1, 1,  1,  6});
    vecs.push_back('{1, 0, 0,   1, 1, 1,  2,  2});
    vecs.push_back('{2, 5, 0,   2, 1, 1,  6, 18});

    foreach (vecs[v]) begin
      en_out = '1; en_pwm = '1;
      do_reset(vecs[v].psc, vecs[v].top, vecs[v].ctr);
      en_out[0] = vecs[v].eo; en_pwm[0] = vecs[v].ep;
      wr(0, vecs[v].duty);
      for (int c = 0; c < 2 * vecs[v].len; c++) step();
      hi = 0; ps = 0;
      for (int c = 0; c < vecs[v].len; c++) begin
        step();
        hi += int'(out[0]);
        ps += int'(period_start);
      end
      check($sformatf("vec%0d_high", v), 64'(hi), 64'(vecs[v].exp_high));
      check($sformatf("vec%0d_ps", v), 64'(ps), 64'(1));
    end

    // Mid-period rewrite, then a write landing exactly on the boundary tick
    en_out = '1; en_pwm = '1;
    do_reset(0, 9, 0);
    wr(2, 2);
    for (int c = 0; c < 14; c++) step();
    wr(2, 5);
    for (int c = 0; c < 12; c++) step();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (cnt_of(m_n) == 9) found = 1; else step();
    end
    check("found_cnt9", 64'(found), 64'(1));
    wr(2, 7);
    hi = 0;
    for (int c = 0; c < 10; c++) begin step(); hi += int'(out[2]); end
    check("bnd_write_high", 64'(hi), 64'(5));
    for (int c = 0; c < 20; c++) step();

    // Static-high, enable drop and out-of-range selects
    en_pwm[3] = 1'b0; en_out[3] = 1'b1;
    step(); step();
    check("static_high", 64'(out[3]), 64'(1));
    en_out[3] = 1'b0;
    step();
    check("en_out_off", 64'(out[3]), 64'(0));
    wr(6, 8); wr(7, 9);
    for (int c = 0; c < 25; c++) step();

    // Asynchronous reset mid-period, then first boundary after release
    en_out = '1; en_pwm = '1;
    do_reset(0, 9, 0);
    wr(0, 8); wr(1, 4);
    for (int c = 0; c < 10; c++) step();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (cnt_of(m_n) == 6) found = 1; else step();
    end
    check("found_cnt6", 64'(found), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_out", 64'(out), 64'(0));
    check("async_ps", 64'(period_start), 64'(0));
    check("async_cnt", 64'(u_dut.cnt), 64'(0));
    do_reset(0, 9, 0);
    first = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (period_start && first == 0) first = c;
    end
    check("first_ps", 64'(first), 64'(10));
    check("post_rst_out", 64'(out), 64'(0));

    // Random enables and writes under random fixed timebase settings
    for (int it = 0; it < 8; it++) begin
      en_out = NCH'($urandom); en_pwm = NCH'($urandom);
      do_reset($urandom_range(0, 3), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 9) == 0) en_out = NCH'($urandom);
        if ($urandom_range(0, 9) == 0) en_pwm = NCH'($urandom);
        duty_wr    = ($urandom_range(0, 3) == 0);
        duty_sel   = SW'($urandom_range(0, 7));
        duty_wdata = ($urandom_range(0, 7) == 0) ? CW'(255) : CW'($urandom_range(0, cfg_top + 2));
        step();
        duty_wr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
